// File: rtl/tree_adder_pkg.sv
// Shared types for the tree adder command sequencer: command codes, FSM states,
// source-plane encoding and the fold-level helper.
package tree_adder_pkg;

   localparam int TA_CMD_W = 4;

   typedef enum logic [TA_CMD_W-1:0] {
      CMD_IDLE      = 4'd0,
      CMD_LOAD_MULT = 4'd1,
      CMD_LOAD_SHA  = 4'd2,
      CMD_LOAD_SHB  = 4'd3,
      CMD_FOLD      = 4'd4,
      CMD_HOLD      = 4'd5
   } ta_cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FOLD,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } ta_state_e;

   typedef enum logic [1:0] {
      SRC_MULT     = 2'd0,
      SRC_SHA      = 2'd1,
      SRC_SHB      = 2'd2,
      SRC_MULT_ALT = 2'd3
   } ta_src_e;

   function automatic int TA_LEVELS(input int side);
      return $clog2(side);
   endfunction

   function automatic ta_cmd_e load_cmd(input logic [1:0] src);
      ta_cmd_e c;
      case (src)
         SRC_SHA: c = CMD_LOAD_SHA;
         SRC_SHB: c = CMD_LOAD_SHB;
         default: c = CMD_LOAD_MULT;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/tree_adder_ctrl_accum.sv
// Saturating running total of delivered reduction results; clear has priority
// over a coincident add.
module tree_adder_accum #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          add_en,
   input  logic [DW-1:0] add_data,
   output logic [DW+7:0] acc
);
   localparam int AW = DW + 8;

   logic [AW:0] sum;

   assign sum = {1'b0, acc} + (AW+1)'(add_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (add_en) begin
         acc <= sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
      end
   end

endmodule

// File: rtl/tree_adder_ctrl.sv
// Command sequencer for the in-place tree adder grid: load, log2(side) folds,
// optional settle, corner capture, result handshake.
// Optional saturating result accumulator enabled by TREE_ADDER_ACCUM_EN.
//
// state   | meaning
// IDLE    | waiting for start handshake, cmd=IDLE
// LOAD    | one cycle, cmd=LOAD_x for latched source plane
// FOLD    | L cycles of cmd=FOLD, level counter 0..L-1
// SETTLE  | SETTLE_CYCLES cycles of cmd=HOLD
// CAPTURE | cmd=HOLD, corner pixel registered into result_data
// DONE    | result_valid high until result_ready
module tree_adder_ctrl
   import tree_adder_pkg::*;
#(
   parameter int IMGSIDELENGTH  = 64,
   parameter int ADDER_DATASIZE = 16,
   parameter int CMD_WIDTH      = 4,
   parameter int SETTLE_CYCLES  = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start_valid,
   output logic                      start_ready,
   input  logic [1:0]                src_sel,
   input  logic                      abort,
   output logic [CMD_WIDTH-1:0]      cmdinput,
   input  logic [ADDER_DATASIZE-1:0] corner_pix_in,
   output logic                      result_valid,
   input  logic                      result_ready,
   output logic [ADDER_DATASIZE-1:0] result_data,
`ifdef TREE_ADDER_ACCUM_EN
   input  logic                      acc_clear,
   output logic [ADDER_DATASIZE+7:0] acc_data,
`endif
   output logic                      busy
);
   localparam int LEVELS = TA_LEVELS(IMGSIDELENGTH);
   localparam int LVL_W  = $clog2(LEVELS);
   localparam logic [LVL_W-1:0] LVL_LAST   = LVL_W'(LEVELS - 1);
   localparam logic [3:0]       SETTLE_TOP = 4'(SETTLE_CYCLES - 1);

   ta_state_e        state, state_next;
   ta_cmd_e          cmd_q, cmd_next;
   logic [1:0]       src_q, src_next;
   logic [LVL_W-1:0] lvl_q, lvl_next;
   logic [3:0]       settle_q, settle_next;
   logic             in_flight;

   assign start_ready  = (state == ST_IDLE);
   assign busy         = (state != ST_IDLE);
   assign result_valid = (state == ST_DONE);
   assign cmdinput     = CMD_WIDTH'(cmd_q);
   assign in_flight    = (state == ST_LOAD) || (state == ST_FOLD) ||
                         (state == ST_SETTLE) || (state == ST_CAPTURE);

   always_comb begin
      state_next  = state;
      src_next    = src_q;
      lvl_next    = lvl_q;
      settle_next = settle_q;
      cmd_next    = CMD_IDLE;

      case (state)
         ST_IDLE: begin
            if (start_valid) begin
               src_next   = src_sel;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            lvl_next   = '0;
            state_next = ST_FOLD;
         end
         ST_FOLD: begin
            if (lvl_q == LVL_LAST) begin
               settle_next = SETTLE_TOP;
               state_next  = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
            end else begin
               lvl_next = lvl_q + 1'b1;
            end
         end
         ST_SETTLE: begin
            // down-counter terminates at zero after SETTLE_CYCLES cycles
            if (settle_q == 4'd0) state_next = ST_CAPTURE;
            else                  settle_next = settle_q - 1'b1;
         end
         ST_CAPTURE: state_next = ST_DONE;
         ST_DONE: begin
            if (result_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase

      if (abort && in_flight) state_next = ST_IDLE;

      // the command register follows the state register on the same edge
      case (state_next)
         ST_IDLE: cmd_next = CMD_IDLE;
         ST_LOAD: cmd_next = load_cmd(src_next);
         ST_FOLD: cmd_next = CMD_FOLD;
         default: cmd_next = CMD_HOLD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cmd_q    <= CMD_IDLE;
         src_q    <= 2'd0;
         lvl_q    <= '0;
         settle_q <= 4'd0;
      end else begin
         state    <= state_next;
         cmd_q    <= cmd_next;
         src_q    <= src_next;
         lvl_q    <= lvl_next;
         settle_q <= settle_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_data <= '0;
      end else if (state == ST_CAPTURE && !abort) begin
         result_data <= corner_pix_in;
      end
   end

`ifdef TREE_ADDER_ACCUM_EN
   tree_adder_accum #(
      .DW(ADDER_DATASIZE)
   ) u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (acc_clear),
      .add_en   (result_valid && result_ready),
      .add_data (result_data),
      .acc      (acc_data)
   );
`endif

endmodule

// File: tb/tb_tree_adder_ctrl.sv
// Directed self-checking bench for tree_adder_ctrl (default parameters);
// accumulator checks are compiled in when TREE_ADDER_ACCUM_EN is defined.
module tb_tree_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid;
   logic        start_ready;
   logic [1:0]  src_sel;
   logic        abort;
   logic [3:0]  cmdinput;
   logic [15:0] corner_pix_in;
   logic        result_valid;
   logic        result_ready;
   logic [15:0] result_data;
   logic        busy;
   logic [15:0] model_val;
`ifdef TREE_ADDER_ACCUM_EN
   logic        acc_clear;
   logic [23:0] acc_data;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // grid model: the corner only holds the true sum while the array is held
   assign corner_pix_in = (cmdinput == 4'd5) ? model_val : 16'hDEAD;

   tree_adder_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_valid   (start_valid),
      .start_ready   (start_ready),
      .src_sel       (src_sel),
      .abort         (abort),
      .cmdinput      (cmdinput),
      .corner_pix_in (corner_pix_in),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .result_data   (result_data),
`ifdef TREE_ADDER_ACCUM_EN
      .acc_clear     (acc_clear),
      .acc_data      (acc_data),
`endif
      .busy          (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

`ifdef TREE_ADDER_ACCUM_EN
   task automatic run_one(input logic clr);
      int k;
      src_sel = 2'd0;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      k = 0;
      while (!result_valid && k < 50) begin
         step();
         k++;
      end
      chk("acc_result_timeout", 32'(k < 50), 32'd1);
      acc_clear = clr;
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      acc_clear = 1'b0;
   endtask
`endif

   initial begin
      #2000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic stable;
      logic seen;
      rst_n = 1'b0;
      start_valid = 1'b0;
      src_sel = 2'd0;
      abort = 1'b0;
      result_ready = 1'b0;
      model_val = 16'h1234;
`ifdef TREE_ADDER_ACCUM_EN
      acc_clear = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd", cmdinput, 4'd0);
      chk("rst_start_ready", start_ready, 1'b1);
      chk("rst_result_valid", result_valid, 1'b0);
      chk("rst_result_data", result_data, 16'h0);
      chk("rst_busy", busy, 1'b0);
`ifdef TREE_ADDER_ACCUM_EN
      chk("rst_acc", acc_data, 24'h0);
`endif
      rst_n = 1'b1;
      step();

      // basic reduction, src 0
      src_sel = 2'd0;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      chk("t1_load_mult", cmdinput, 4'd1);
      chk("t1_busy", busy, 1'b1);
      chk("t1_start_ready", start_ready, 1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("t1_fold%0d", i), cmdinput, 4'd4);
      end
      step();
      chk("t1_capture_hold", cmdinput, 4'd5);
      chk("t1_capture_no_valid", result_valid, 1'b0);
      step();
      chk("t1_valid_cycle9", result_valid, 1'b1);
      chk("t1_data", result_data, 16'h1234);
      chk("t1_done_hold", cmdinput, 4'd5);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("t1_busy_after_hs", busy, 1'b0);
      chk("t1_cmd_after_hs", cmdinput, 4'd0);
      chk("t1_valid_after_hs", result_valid, 1'b0);

      // stall in DONE, src 1
      model_val = 16'h5678;
      src_sel = 2'd1;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      chk("t2_load_sha", cmdinput, 4'd2);
      repeat (8) step();
      chk("t2_valid", result_valid, 1'b1);
      chk("t2_data", result_data, 16'h5678);
      model_val = 16'hBEEF;
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!(result_valid === 1'b1 && result_data === 16'h5678 && cmdinput === 4'd5))
            stable = 1'b0;
      end
      chk("t2_stall_stable", stable, 1'b1);
      result_ready = 1'b1;
      start_valid = 1'b1;
      src_sel = 2'd2;
      step();
      result_ready = 1'b0;
      chk("t2_b2b_idle_ready", start_ready, 1'b1);
      chk("t2_b2b_idle_cmd", cmdinput, 4'd0);
      step();
      chk("t2_b2b_load_shb", cmdinput, 4'd3);

      // start held high with src toggling while busy
      model_val = 16'h0F0F;
      for (int i = 0; i < 6; i++) begin
         src_sel = 2'(i);
         step();
         chk($sformatf("t4_fold%0d", i), cmdinput, 4'd4);
         chk($sformatf("t4_not_ready%0d", i), start_ready, 1'b0);
      end
      start_valid = 1'b0;
      step();
      step();
      chk("t4_valid", result_valid, 1'b1);
      chk("t4_data", result_data, 16'h0F0F);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;

      // abort in third FOLD cycle, src 3 maps to the mult plane
      src_sel = 2'd3;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      chk("t3_src3_load_mult", cmdinput, 4'd1);
      step();
      step();
      step();
      chk("t3_fold3", cmdinput, 4'd4);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t3_abort_cmd", cmdinput, 4'd0);
      chk("t3_abort_ready", start_ready, 1'b1);
      chk("t3_abort_busy", busy, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (result_valid !== 1'b0) seen = 1'b1;
      end
      chk("t3_no_result", seen, 1'b0);

      // abort while DONE is ignored
      model_val = 16'h1111;
      src_sel = 2'd0;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      repeat (8) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_abort_done_valid", result_valid, 1'b1);
      chk("t6_abort_done_data", result_data, 16'h1111);
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;

      // asynchronous reset mid-FOLD
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_arst_cmd", cmdinput, 4'd0);
      chk("t5_arst_ready", start_ready, 1'b1);
      chk("t5_arst_busy", busy, 1'b0);
      chk("t5_arst_valid", result_valid, 1'b0);
      chk("t5_arst_data", result_data, 16'h0);
      step();
      rst_n = 1'b1;
      step();

`ifdef TREE_ADDER_ACCUM_EN
      model_val = 16'hFFFF;
      run_one(1'b0);
      run_one(1'b0);
      chk("acc_two", acc_data, 24'h01FFFE);
      for (int i = 2; i < 300; i++) run_one(1'b0);
      chk("acc_saturated", acc_data, 24'hFFFFFF);
      run_one(1'b1);
      chk("acc_clear_wins", acc_data, 24'h0);
      run_one(1'b0);
      chk("acc_after_clear", acc_data, 24'h00FFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tree_adder_ctrl.md
# tree_adder_ctrl

Command sequencer driving the shared `cmdinput` bus of the in-place tree adder grid and collecting its reduced sum. Accepts a frame-reduction request (source plane select) over a valid/ready handshake, issues the load command, then the log2(IMGSIDELENGTH) fold commands that crunch the grid into pixel [0][0]. It then samples that corner pixel and returns the scalar over a second valid/ready handshake. Sits between the frame scheduler and the tree adder array.

## Interface
- `IMGSIDELENGTH`, 64: grid side in pixels; power of two, ≥4.
- `ADDER_DATASIZE`, 16: pixel/sum width.
- `CMD_WIDTH`, 4: width of the command bus.
- `SETTLE_CYCLES`, 0: extra wait cycles after the last fold before the corner is sampled (0..15).

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start_valid` in 1: reduction request.
- `start_ready` out 1: high only in IDLE.
- `src_sel` in 2: plane to load. 0 = mult, 1 = shadowA, 2 = shadowB, 3 = mult. Sampled on the start handshake.
- `abort` in 1: synchronous cancel of an in-flight reduction.
- `cmdinput` out CMD_WIDTH: command to every tree adder element, registered.
- `corner_pix_in` in ADDER_DATASIZE: grid output pixel [0][0].
- `result_valid` out 1: result available.
- `result_ready` in 1: consumer accepts result.
- `result_data` out ADDER_DATASIZE: sampled sum.
- `busy` out 1: high in any state except IDLE.

## Operation
- Command codes: CMD_IDLE=0, CMD_LOAD_MULT=1, CMD_LOAD_SHA=2, CMD_LOAD_SHB=3, CMD_FOLD=4, CMD_HOLD=5. All other codes are never driven.
- States and transitions:
  - IDLE: cmd=IDLE. On start handshake: latch src_sel, go to LOAD.
  - LOAD: one cycle; cmd=LOAD_x per latched src. Go to FOLD.
  - FOLD: L = log2(IMGSIDELENGTH) consecutive cycles with cmd=FOLD. A level counter counts 0..L-1. Then go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
  - SETTLE: SETTLE_CYCLES cycles with cmd=HOLD.
  - CAPTURE: one cycle; cmd=HOLD; register corner_pix_in into result_data. Go to DONE.
  - DONE: result_valid=1, cmd=HOLD, result_data stable. On result_ready, go to IDLE.
- Width rule: the sum wraps modulo 2^ADDER_DATASIZE inside the array. The controller applies no arithmetic to it.
- abort in LOAD/FOLD/SETTLE/CAPTURE: next state IDLE, cmd=IDLE next cycle, no result produced. abort in DONE or IDLE: ignored; a pending result is still delivered.
- start_valid while busy: not accepted, no effect.
- Reset mid-operation: immediate return to IDLE; the partial reduction is discarded.

## Timing
- Reset values: cmdinput=CMD_IDLE, start_ready=1, result_valid=0, result_data=0, busy=0. With the macro: acc_data=0.
- Cycle numbering: start handshake at edge 0. cmd=LOAD during cycle 1. FOLD during cycles 2..L+1. SETTLE follows, then CAPTURE at cycle L+2+SETTLE_CYCLES. result_valid rises the following cycle.
- Default latency (L=6, SETTLE_CYCLES=0): result_valid at cycle 9.
- Back-to-back: the result handshake returns the block to IDLE. The next start is accepted at the earliest one cycle after the result handshake.
- The cmdinput change and the state change occur on the same edge.

## Configuration
- `TREE_ADDER_ACCUM_EN` defined: adds input `acc_clear` (1) and output `acc_data` (ADDER_DATASIZE+8).
  - Every result handshake adds zero-extended result_data to acc_data.
  - The add saturates at all-ones.
  - acc_clear zeroes acc_data synchronously. When acc_clear coincides with a handshake, the clear wins and the new result is not added.
- Macro undefined: no accumulator and no extra ports. Behaviour is otherwise identical.

## Structure
- Package `tree_adder_pkg` holds:
  - the command code localparams/enum, sized by CMD_WIDTH;
  - the state enum;
  - the src_sel encoding;
  - `TA_LEVELS(side)` = $clog2(side).
- One natural sub-module: `tree_adder_accum` (saturating accumulator), instantiated only under TREE_ADDER_ACCUM_EN.

## Test plan
- Reset release, start with src_sel=0, corner model returns 16'h1234 at capture:
  - cmd sequence is 1, then 4 ×6, then 5.
  - result_valid at cycle 9 with data 16'h1234.
  - busy is low after the handshake.
- result_ready held low for 20 cycles: result_valid and result_data stay stable and cmd stays HOLD. The first start after the handshake is accepted one cycle later.
- abort asserted in the third FOLD cycle: cmd=IDLE next cycle, no result_valid, start_ready=1.
- start_valid held high while busy, src_sel toggling: only the first request is accepted. The load code matches src_sel at acceptance. src_sel=3 produces code 1.
- rst_n pulsed low asynchronously mid-FOLD: outputs return to reset values without waiting for a clock edge.
- TREE_ADDER_ACCUM_EN, ADDER_DATASIZE=16: feed 300 results of 16'hFFFF.
  - acc_data saturates at 24'hFFFFFF.
  - acc_clear coinciding with a handshake gives 0.
